// File: rtl/apb_arb_pkg.sv
// Shared constants and state type for the APB arbiter.
// Optional build macro: APB_ARB_RR_EN selects round-robin arbitration.
package apb_arb_pkg;

  localparam int unsigned ADDR_W   = 9;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NREQ_MAX = 4;
  localparam int unsigned IDX_W    = $clog2(NREQ_MAX);

  typedef enum logic [1:0] {
    ARB   = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    CPL   = 2'b11
  } state_t;

endpackage

// File: rtl/apb_arb_pick.sv
// Combinational winner selection among pending requesters.
// APB_ARB_RR_EN defined: search starts at ptr and wraps; otherwise lowest index wins.
module apb_arb_pick
  import apb_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]  req,
`ifdef APB_ARB_RR_EN
  input  logic [IDX_W-1:0] ptr,
`endif
  output logic [NREQ-1:0]  win_onehot,
  output logic [IDX_W-1:0] win_idx
);

  // First pending requester in search order becomes the winner
  always_comb begin
    logic              found;
    logic [NREQ-1:0]   shifted;
    logic [31:0]       cand;
    win_onehot = '0;
    win_idx    = '0;
    found      = 1'b0;
    shifted    = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef APB_ARB_RR_EN
      cand = (32'(ptr) + i) % NREQ;
`else
      cand = i;
`endif
      shifted = req >> cand;
      if (!found && shifted[0]) begin
        found      = 1'b1;
        win_onehot = NREQ'(1) << cand;
        win_idx    = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// Shares one APB master among NREQ requesters, one transfer per grant.
// Optional build macro: APB_ARB_RR_EN enables round-robin arbitration.
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NREQ-1:0]        REQ,
  input  logic [NREQ-1:0]        REQ_WRITE,
  input  logic [ADDR_W*NREQ-1:0] REQ_ADDR,
  input  logic [DATA_W*NREQ-1:0] REQ_WDATA,
  output logic [NREQ-1:0]        GNT,
  output logic [NREQ-1:0]        DONE,
  output logic [DATA_W-1:0]      RDATA,
  output logic                   EN,
  output logic                   WRITE,
  output logic [ADDR_W-1:0]      ADDR,
  output logic [DATA_W-1:0]      WDATA,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PREADY,
  input  logic [DATA_W-1:0]      PRDATA
);

  state_t              state_q, state_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic                en_q, en_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NREQ-1:0]     win_onehot;
  logic [IDX_W-1:0]    win_idx;
  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
`ifdef APB_ARB_RR_EN
  logic [IDX_W-1:0]    ptr_q, ptr_d;
`endif

  apb_arb_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req        (REQ),
`ifdef APB_ARB_RR_EN
    .ptr        (ptr_q),
`endif
    .win_onehot (win_onehot),
    .win_idx    (win_idx)
  );

  // Payload of the current winner
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_write = REQ_WRITE[i];
        sel_addr  = REQ_ADDR[i*ADDR_W +: ADDR_W];
        sel_wdata = REQ_WDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = done_q;
    en_d    = en_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef APB_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      ARB: begin
        if (|REQ) begin
          state_d = ISSUE;
          gnt_d   = win_onehot;
          en_d    = 1'b1;
          write_d = sel_write;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
`ifdef APB_ARB_RR_EN
          ptr_d   = IDX_W'((32'(win_idx) + 32'd1) % NREQ);
`endif
        end
      end
      ISSUE: begin
        // Dropping EN at SETUP keeps the master from chaining a second transfer
        if (PSEL && !PENABLE) begin
          state_d = WAIT;
          en_d    = 1'b0;
        end
      end
      WAIT: begin
        if (PSEL && PENABLE && PREADY) begin
          state_d = CPL;
          done_d  = gnt_q;
          if (!write_q) rdata_d = PRDATA;
        end
      end
      CPL: begin
        state_d = ARB;
        done_d  = '0;
        gnt_d   = '0;
      end
      default: state_d = ARB;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ARB;
      gnt_q   <= '0;
      done_q  <= '0;
      en_q    <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef APB_ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      en_q    <= en_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef APB_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign GNT   = gnt_q;
  assign DONE  = done_q;
  assign RDATA = rdata_q;
  assign EN    = en_q;
  assign WRITE = write_q;
  assign ADDR  = addr_q;
  assign WDATA = wdata_q;

endmodule
